// File: rtl/tm1638_responder_if.sv
// TM1638 3-wire link: controller drives sck/cs/dio_in, responder returns dio_out/dio_oe.
interface tm1638_responder_if;
   logic sck;
   logic cs;
   logic dio_in;
   logic dio_out;
   logic dio_oe;

   modport master (output sck, cs, dio_in, input dio_out, dio_oe);
   modport slave  (input sck, cs, dio_in, output dio_out, dio_oe);
endinterface

// File: rtl/tm1638_responder.sv
// TM1638-compatible responder: LSB-first serial command decoder with display RAM,
// display-control register and key-scan readback over DIO.
module tm1638_responder #(
   parameter int unsigned NUM_BYTES   = 16,
   parameter int unsigned KEY_BYTES   = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   tm1638_responder_if.slave      bus,
   input  logic [8*KEY_BYTES-1:0] key_data,
   output logic [7:0]             display_ram [NUM_BYTES],
   output logic                   disp_on,
   output logic [2:0]             brightness,
   output logic                   wr_strobe,
   output logic [3:0]             wr_addr,
   output logic                   frame_err
);

   localparam int unsigned KEY_BITS = 8 * KEY_BYTES;
   localparam int unsigned CNT_W    = $clog2(KEY_BITS + 1);

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_WRITE, S_READ, S_IGNORE} state_t;

   state_t                r_state, w_state_next;
   logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_dio_sync;
   logic                  r_sck_d, r_cs_d;
   logic                  w_sck, w_cs, w_dio;
   logic                  w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
   logic                  w_in_frame, w_byte_done;
   logic [7:0]            w_byte;

   logic [2:0]            r_bitcnt;
   logic [6:0]            r_shift;
   logic                  r_fixed;
   logic [3:0]            r_ptr;
   logic [7:0]            r_ram [NUM_BYTES];
   logic                  r_disp_on;
   logic [2:0]            r_bright;
   logic                  r_wr_strobe, r_frame_err;
   logic [3:0]            r_wr_addr;
   logic                  r_dio_oe, r_dio_out;
   logic [KEY_BITS-2:0]   r_keys;
   logic [CNT_W-1:0]      r_rd_left;
   logic                  r_rd_armed;

   // cs sync resets low so a frame already in progress at reset release never
   // looks like a falling edge; cs must first be seen high.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sck_sync <= '1;
         r_cs_sync  <= '0;
         r_dio_sync <= '1;
         r_sck_d    <= 1'b1;
         r_cs_d     <= 1'b0;
      end else begin
         r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], bus.sck};
         r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs};
         r_dio_sync <= {r_dio_sync[SYNC_STAGES-2:0], bus.dio_in};
         r_sck_d    <= w_sck;
         r_cs_d     <= w_cs;
      end
   end

   assign w_sck       = r_sck_sync[SYNC_STAGES-1];
   assign w_cs        = r_cs_sync[SYNC_STAGES-1];
   assign w_dio       = r_dio_sync[SYNC_STAGES-1];
   assign w_sck_rise  = w_sck & ~r_sck_d;
   assign w_sck_fall  = ~w_sck & r_sck_d;
   assign w_cs_rise   = w_cs & ~r_cs_d;
   assign w_cs_fall   = ~w_cs & r_cs_d;
   assign w_in_frame  = (r_state != S_IDLE);
   assign w_byte      = {w_dio, r_shift};
   assign w_byte_done = w_in_frame & w_sck_rise & (r_bitcnt == 3'd7) & ~w_cs_rise;

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (w_cs_rise) begin
         w_state_next = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: if (w_cs_fall) w_state_next = S_CMD;
            S_CMD: begin
               if (w_byte_done) begin
                  case (w_byte[7:6])
                     2'b01:   w_state_next = w_byte[1] ? S_READ : S_IGNORE;
                     2'b11:   w_state_next = S_WRITE;
                     default: w_state_next = S_IGNORE;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_bitcnt    <= '0;
         r_shift     <= '0;
         r_fixed     <= 1'b0;
         r_ptr       <= '0;
         r_disp_on   <= 1'b0;
         r_bright    <= '0;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= '0;
         r_frame_err <= 1'b0;
         r_dio_oe    <= 1'b0;
         r_dio_out   <= 1'b1;
         r_keys      <= '0;
         r_rd_left   <= '0;
         r_rd_armed  <= 1'b0;
         for (int unsigned i = 0; i < NUM_BYTES; i++) r_ram[i] <= '0;
      end else begin
         r_wr_strobe <= 1'b0;
         r_frame_err <= 1'b0;

         if (w_cs_rise || w_cs_fall) begin
            r_bitcnt <= '0;
         end else if (w_in_frame && w_sck_rise) begin
            r_bitcnt <= r_bitcnt + 3'd1;
            r_shift  <= w_byte[7:1];
         end

         if (w_cs_rise) begin
            r_frame_err <= (r_bitcnt != 3'd0);
            r_dio_oe    <= 1'b0;
            r_dio_out   <= 1'b1;
         end else begin
            if (w_byte_done) begin
               unique case (r_state)
                  S_CMD: begin
                     case (w_byte[7:6])
                        2'b01: begin
                           r_fixed <= w_byte[2];
                           if (w_byte[1]) begin
                              r_keys     <= key_data[KEY_BITS-1:1];
                              r_dio_out  <= key_data[0];
                              r_dio_oe   <= 1'b1;
                              r_rd_left  <= CNT_W'(KEY_BITS);
                              r_rd_armed <= 1'b0;
                           end
                        end
                        2'b10: begin
                           r_disp_on <= w_byte[3];
                           r_bright  <= w_byte[2:0];
                        end
                        2'b11: r_ptr <= 4'({1'b0, w_byte[3:0]} % 5'(NUM_BYTES));
                        default: ;
                     endcase
                  end
                  S_WRITE: begin
                     r_ram[r_ptr] <= w_byte;
                     r_wr_strobe  <= 1'b1;
                     r_wr_addr    <= r_ptr;
                     if (!r_fixed)
                        r_ptr <= (r_ptr == 4'(NUM_BYTES - 1)) ? '0 : r_ptr + 4'd1;
                  end
                  default: ;
               endcase
            end

            // The sck fall right after the command byte precedes the first
            // sampled bit, so advancing waits for a rise seen in S_READ.
            if (r_state == S_READ) begin
               if (w_sck_rise) r_rd_armed <= 1'b1;
               if (w_sck_fall && r_rd_armed && r_dio_oe) begin
                  if (r_rd_left == CNT_W'(1)) begin
                     r_dio_oe  <= 1'b0;
                     r_dio_out <= 1'b1;
                  end else begin
                     r_dio_out <= r_keys[0];
                     r_keys    <= {1'b1, r_keys[KEY_BITS-2:1]};
                     r_rd_left <= r_rd_left - CNT_W'(1);
                  end
               end
            end
         end
      end
   end

   assign bus.dio_out = r_dio_out;
   assign bus.dio_oe  = r_dio_oe;
   assign display_ram = r_ram;
   assign disp_on     = r_disp_on;
   assign brightness  = r_bright;
   assign wr_strobe   = r_wr_strobe;
   assign wr_addr     = r_wr_addr;
   assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_tm1638_responder.sv
// Bench for tm1638_responder: vector table, hand corner sequences and random
// frames checked against a frame-level model of the display and key protocol.
module tb_tm1638_responder;

   localparam int HALF = 6;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [31:0] bytes;
      int          n;
      int          idx;
      logic [7:0]  ram_v;
      logic        on;
      logic [2:0]  bri;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] key_data;
   logic [7:0]  display_ram [16];
   logic        disp_on;
   logic [2:0]  brightness;
   logic        wr_strobe;
   logic [3:0]  wr_addr;
   logic        frame_err;

   tm1638_responder_if bus();

   tm1638_responder #(.NUM_BYTES(16), .KEY_BYTES(4), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .bus(bus), .key_data(key_data),
      .display_ram(display_ram), .disp_on(disp_on), .brightness(brightness),
      .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_ram [16];
   logic       m_on;
   logic [2:0] m_bri;
   logic       m_fixed;
   int         m_ptr;
   int         exp_ferr = 0;
   int         ferr_cnt = 0;
   int         exp_addr[$];
   int         obs_addr[$];

   always @(negedge clk) begin
      if (wr_strobe === 1'b1) obs_addr.push_back(int'(wr_addr));
      if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic half();
      repeat (HALF) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      bus.sck = 1'b0;
      bus.dio_in = b;
      half();
      bus.sck = 1'b1;
      half();
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
   endtask

   task automatic frame_start();
      bus.cs = 1'b0;
      half();
   endtask

   task automatic frame_end();
      bus.cs = 1'b1;
      repeat (HALF + 4) @(negedge clk);
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
      m_on = 1'b0;
      m_bri = 3'd0;
      m_fixed = 1'b0;
      m_ptr = 0;
   endfunction

   // Frame-level rules: first byte is the command, later bytes are RAM data
   // only after an address command.
   function automatic void model_frame(input bq_t q);
      if (q.size() == 0) return;
      case (q[0][7:6])
         2'b01: m_fixed = q[0][2];
         2'b10: begin m_on = q[0][3]; m_bri = q[0][2:0]; end
         2'b11: begin
            m_ptr = int'(q[0][3:0]) % 16;
            for (int k = 1; k < q.size(); k++) begin
               m_ram[m_ptr] = q[k];
               exp_addr.push_back(m_ptr);
               if (!m_fixed) m_ptr = (m_ptr + 1) % 16;
            end
         end
         default: ;
      endcase
   endfunction

   task automatic check_strobes();
      chk("strobe_count", obs_addr.size(), exp_addr.size());
      if (obs_addr.size() == exp_addr.size())
         foreach (exp_addr[k]) chk($sformatf("wr_addr[%0d]", k), obs_addr[k], exp_addr[k]);
      obs_addr.delete();
      exp_addr.delete();
      chk("frame_err_count", ferr_cnt, exp_ferr);
   endtask

   task automatic check_regs();
      chk("disp_on", disp_on, m_on);
      chk("brightness", brightness, m_bri);
      chk("idle_dio_oe", bus.dio_oe, 1'b0);
      chk("idle_dio_out", bus.dio_out, 1'b1);
      for (int i = 0; i < 16; i++) chk($sformatf("ram[%0d]", i), display_ram[i], m_ram[i]);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_disp_on"}, disp_on, 1'b0);
      chk({tag, "_brightness"}, brightness, 3'd0);
      chk({tag, "_dio_oe"}, bus.dio_oe, 1'b0);
      chk({tag, "_dio_out"}, bus.dio_out, 1'b1);
      chk({tag, "_wr_strobe"}, wr_strobe, 1'b0);
      chk({tag, "_wr_addr"}, wr_addr, 4'd0);
      chk({tag, "_frame_err"}, frame_err, 1'b0);
      for (int i = 0; i < 16; i++) chk($sformatf("%s_ram[%0d]", tag, i), display_ram[i], 8'h00);
   endtask

   task automatic do_frame(input bq_t q, input int extra);
      frame_start();
      foreach (q[k]) send_byte(q[k]);
      for (int i = 0; i < extra; i++) send_bit(1'($urandom_range(0, 1)));
      frame_end();
      model_frame(q);
      if (extra != 0) exp_ferr++;
      check_strobes();
      check_regs();
   endtask

   // Reads nbits key bits, sampling dio_out just before each sck rise.
   task automatic read_frame(input logic [7:0] cmd, input logic [31:0] keys, input int nbits);
      logic [31:0] got;
      logic [31:0] mask;
      got = '0;
      mask = '1;
      if (nbits < 32) mask = (32'd1 << nbits) - 32'd1;
      key_data = keys;
      frame_start();
      send_byte(cmd);
      for (int i = 0; i < nbits; i++) begin
         bus.sck = 1'b0;
         half();
         got[i] = bus.dio_out;
         if (i == 0 || i == nbits - 1) chk($sformatf("dio_oe_bit%0d", i), bus.dio_oe, 1'b1);
         bus.sck = 1'b1;
         half();
      end
      bus.sck = 1'b0;
      half();
      if (nbits == 32) begin
         chk("dio_oe_after_last", bus.dio_oe, 1'b0);
         chk("dio_out_after_last", bus.dio_out, 1'b1);
      end
      bus.cs = 1'b1;
      half();
      chk("dio_oe_after_cs", bus.dio_oe, 1'b0);
      bus.sck = 1'b1;
      repeat (4) @(negedge clk);
      chk($sformatf("key_bits_%0d", nbits), got & mask, keys & mask);
      m_fixed = cmd[2];
      check_strobes();
      check_regs();
   endtask

   initial begin
      vec_t vt [10];
      bq_t q;
      logic [7:0] c;
      int kind, extra, n;

      vt[0] = '{32'h0000008F, 1, 0,  8'h01, 1'b1, 3'd7};
      vt[1] = '{32'h00000080, 1, 1,  8'h02, 1'b0, 3'd0};
      vt[2] = '{32'h00000044, 1, 2,  8'h03, 1'b0, 3'd0};
      vt[3] = '{32'h0055AAC3, 3, 3,  8'h55, 1'b0, 3'd0};
      vt[4] = '{32'h00000040, 1, 4,  8'h05, 1'b0, 3'd0};
      vt[5] = '{32'h332211CE, 4, 0,  8'h33, 1'b0, 3'd0};
      vt[6] = '{32'h0000008B, 1, 14, 8'h11, 1'b1, 3'd3};
      vt[7] = '{32'h00009900, 2, 15, 8'h22, 1'b1, 3'd3};
      vt[8] = '{32'h00000087, 1, 1,  8'h02, 1'b0, 3'd7};
      vt[9] = '{32'h000077C5, 2, 5,  8'h77, 1'b0, 3'd7};

      reset = 1'b0;
      bus.sck = 1'b1;
      bus.cs = 1'b1;
      bus.dio_in = 1'b1;
      key_data = '0;
      model_reset();
      repeat (5) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b1;
      repeat (5) @(negedge clk);

      // Sequential fill 0x01..0x10 in auto-increment mode.
      q = {8'h40};
      do_frame(q, 0);
      q = {8'hC0};
      for (int i = 1; i <= 16; i++) q.push_back(8'(i));
      do_frame(q, 0);
      chk("fill_ram15", display_ram[15], 8'h10);

      for (int t = 0; t < 10; t++) begin
         q = {};
         for (int k = 0; k < vt[t].n; k++) q.push_back(vt[t].bytes[8*k +: 8]);
         do_frame(q, 0);
         chk($sformatf("vec%0d_ram[%0d]", t, vt[t].idx), display_ram[vt[t].idx], vt[t].ram_v);
         chk($sformatf("vec%0d_disp_on", t), disp_on, vt[t].on);
         chk($sformatf("vec%0d_brightness", t), brightness, vt[t].bri);
      end

      read_frame(8'h42, 32'h8040_2001, 32);
      read_frame(8'h42, 32'hA5C3_0F96, 16);

      // Complete byte kept, trailing 3 bits flagged.
      q = {8'hC0, 8'hAB};
      do_frame(q, 3);
      chk("partial_ram0", display_ram[0], 8'hAB);

      // 8th sck rise and cs rise arrive together: byte dropped with frame_err.
      frame_start();
      send_byte(8'hC2);
      for (int i = 0; i < 7; i++) send_bit(1'b1);
      bus.sck = 1'b0;
      half();
      bus.sck = 1'b1;
      bus.cs = 1'b1;
      repeat (HALF + 4) @(negedge clk);
      q = {8'hC2};
      model_frame(q);
      exp_ferr++;
      check_strobes();
      check_regs();

      // Reset in the middle of a byte, then edges ignored until a fresh cs fall.
      q = {8'h8F};
      do_frame(q, 0);
      q = {8'hC9, 8'h5A};
      do_frame(q, 0);
      frame_start();
      send_byte(8'hC0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("midreset");
      reset = 1'b1;
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      send_byte(8'hEE);
      frame_end();
      model_reset();
      check_strobes();
      check_regs();

      for (int r = 0; r < 30; r++) begin
         kind = $urandom_range(0, 4);
         extra = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : 0;
         q = {};
         case (kind)
            0: begin c = 8'h40 | (8'($urandom) & 8'h3D); q.push_back(c); do_frame(q, extra); end
            1: begin c = 8'h80 | (8'($urandom) & 8'h3F); q.push_back(c); do_frame(q, extra); end
            2: begin
               c = 8'hC0 | (8'($urandom) & 8'h3F);
               q.push_back(c);
               n = $urandom_range(1, 6);
               for (int k = 0; k < n; k++) q.push_back(8'($urandom));
               do_frame(q, extra);
            end
            3: begin
               c = 8'h42 | (8'($urandom) & 8'h3D);
               read_frame(c, $urandom, ($urandom_range(0, 1) == 0) ? 32 : 8 * $urandom_range(1, 3));
            end
            default: begin
               c = 8'($urandom) & 8'h3F;
               q.push_back(c);
               n = $urandom_range(0, 2);
               for (int k = 0; k < n; k++) q.push_back(8'($urandom));
               do_frame(q, extra);
            end
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tm1638_responder.md
Name: tm1638_responder

Overview:
- Synthesizable TM1638-compatible 3-wire SPI peripheral: the responder end of the LED&KEY link, which is LSB-first with CS active-low.
- Decodes data, display-control and address commands into an internal 16-byte display RAM. Serves key-scan reads back over DIO.
- Serves as a loopback target for our controller on spare GPIO.
- Serves as a bus-functional model in controller regressions.

Parameters:
- NUM_BYTES, 16, display RAM depth; address field is 4 bits, wraps modulo NUM_BYTES.
- KEY_BYTES, 4, bytes returned by a key-read command.
- SYNC_STAGES, 2, synchronizer flops on sck/dio_in/cs (minimum 2).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low: the block resets on a clk edge while reset==0.
- sck  in  1  serial clock from controller, asynchronous to clk; idles high.
- cs  in  1  chip select, active-low, asynchronous.
- dio_in  in  1  serial data from controller, asynchronous.
- dio_out  out  1  serial data to controller during key reads.
- dio_oe  out  1  high when dio_out is to be driven onto DIO.
- key_data  in  8*KEY_BYTES  key-scan bytes; byte 0 = bits [7:0], sent first.
- display_ram  out  8 x NUM_BYTES  unpacked array of display bytes.
- disp_on  out  1  display-enable bit from the last display-control command.
- brightness  out  3  pulse-width field from the last display-control command.
- wr_strobe  out  1  one-clk pulse per RAM byte written.
- wr_addr  out  4  address of that write; valid with wr_strobe.
- frame_err  out  1  one-clk pulse when CS rises with a partial byte pending.

Behaviour:
- Reset values: display_ram all 0x00, disp_on 0, brightness 0, dio_oe 0, dio_out 1, wr_strobe 0, wr_addr 0, frame_err 0. Write mode = auto-increment, address pointer 0, state S_IDLE.
- Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized signals, so detection latency is SYNC_STAGES+1 clk. Requirement: sck high and low each ≥ 4 clk, which 2.5 MHz sck at 50 MHz clk meets.
- Bit capture:
  - Sample dio on sck rising edge while cs low.
  - Shift in LSB first.
  - A byte completes on the 8th rising edge; the bit counter then clears.
- CS rising edge:
  - Return to S_IDLE from any state and clear the bit counter.
  - If bit counter ≠ 0, discard the partial byte and pulse frame_err.
  - Drop dio_oe in the same clk.
- States and transitions:
  - S_IDLE: on cs falling → S_CMD.
  - S_CMD: the first complete byte is decoded by bits[7:6]:
    - 01 (data command): bit2 = 1 selects fixed address, 0 selects auto-increment. If bit1 = 1, latch key_data → S_READ; else → S_IGNORE. bits 3, 5, 4, 0 are ignored.
    - 10 (display control): disp_on ← bit3, brightness ← bits[2:0] → S_IGNORE.
    - 11 (address set): pointer ← bits[3:0] → S_WRITE.
    - 00: ignored → S_IGNORE.
  - S_WRITE: on each complete byte:
    - display_ram[pointer] ← byte; wr_strobe = 1 for one clk with wr_addr = pointer.
    - In auto-increment mode, pointer ← pointer+1 mod NUM_BYTES (15 → 0). In fixed mode the pointer holds.
    - Unlimited bytes per frame.
  - S_READ:
    - Set dio_oe = 1 and present key bit 0 on dio_out in the clk after command completion.
    - On each subsequent sck falling edge, advance to the next bit, LSB first, byte 0 first.
    - After 8*KEY_BYTES bits, dio_out = 1 and dio_oe = 0; the state stays S_READ until cs rises.
    - Bytes clocked in during S_READ are ignored.
  - S_IGNORE: discard bytes until cs rises.
- Mode persistence:
  - The data-command mode (fixed or auto) persists across frames until the next data command.
  - The pointer persists, but every write frame begins with an address command.
- Simultaneity: if a byte completes and cs rises in the same clk, cs wins and the byte is discarded with frame_err.
- Reset mid-frame: all state returns to reset values immediately. Input edges are ignored until cs is next seen falling after reset release.
- RAM writes land 1 clk after byte completion.

Test Plan:
- Frame 0x40, then frame 0xC0 followed by 16 bytes 0x01..0x10 → display_ram[i] = i+1, 16 wr_strobe pulses with wr_addr 0..15.
- Frame 0x44, then frame 0xC3 0xAA 0x55 → display_ram[3] = 0x55, other bytes unchanged, two strobes both at wr_addr 3.
- Auto mode, frame 0xCE 0x11 0x22 0x33 → ram[14] = 0x11, ram[15] = 0x22, ram[0] = 0x33 (wrap-around).
- Frame 0x8F → disp_on = 1, brightness = 7. Then frame 0x80 → disp_on = 0, brightness = 0; RAM untouched.
- key_data = 0x8040_2001, frame 0x42 then 32 sck clocks → dio_out sampled on sck rising edges reads bytes 0x01, 0x20, 0x40, 0x80. dio_oe high through the last bit and low after cs rises.
- Partial-byte and reset checks:
  - Frame 0xC0 0xAB plus 3 extra bits, then cs rises → ram[0] = 0xAB and a single frame_err pulse.
  - reset = 0 mid-byte → all outputs return to reset values.
